fetch_redirect: RTL and testbench
=================================

FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset; asynchronous assert, active-low; synchronous deassert by clk.
REQ-003 leap  in  1  redirect request from decode (branch taken or jump), qualified by IF/ID valid.
REQ-004 target  in  [0:31]  redirect PC; bit 0 MSB; bits 30:31 ignored, taken as 00.
REQ-005 stall  in  1  hazard stall; IF/ID must hold.
REQ-006 imem_req  out  1  instruction memory request.
REQ-007 imem_addr  out  [0:31]  fetch address.
REQ-008 imem_ack  in  1  memory completion; imem_data valid in the same cycle.
REQ-009 imem_data  in  [0:31]  fetched instruction.
REQ-010 instr_out  out  [0:31]  IF/ID instruction register.
REQ-011 pc4_out  out  [0:31]  IF/ID PC+4 register (link value for jal/jalr).
REQ-012 valid_out  out  1  IF/ID holds a live instruction.
REQ-013 flush_out  out  1  one-cycle pulse marking a squash.

Function
REQ-014 States SHALL be FETCH, HOLD, DRAIN; reset state FETCH.
REQ-015 Registered PC SHALL drive imem_addr; imem_req=1 in FETCH and DRAIN, 0 in HOLD.
REQ-016 imem_addr SHALL NOT change while imem_req=1 and imem_ack=0 (memory protocol rule).
REQ-017 Effective redirect: redirect = leap & valid_out & ~stall; leap with stall=1 or valid_out=0 SHALL be ignored.
REQ-018 FETCH, ack=1, redirect=0, stall=0: IF/ID <= {imem_data, PC+4, valid=1}; PC <= PC+4; stay FETCH.
REQ-019 FETCH, ack=1, stall=1: IF/ID unchanged; imem_data and PC+4 captured in a one-entry holding buffer; PC <= PC+4; go HOLD.
REQ-020 HOLD, stall=0, redirect=0: IF/ID <= holding buffer, valid=1; go FETCH.
REQ-021 FETCH, ack=0, stall=0, redirect=0: valid_out <= 0 (bubble); stall=1: IF/ID unchanged.
REQ-022 Redirect in FETCH with ack=1: fetched data discarded; PC <= {target[0:29],00}; valid_out <= 0; stay FETCH.
REQ-023 Redirect in FETCH with ack=0: valid_out <= 0; PC unchanged; save {target[0:29],00} in redirect register; go DRAIN.
REQ-024 DRAIN: keep req/addr until ack; on ack discard data, PC <= saved target, go FETCH; valid_out stays 0; new leap ignored (valid_out=0).
REQ-025 Redirect in HOLD: holding buffer discarded; PC <= {target[0:29],00}; valid_out <= 0; go FETCH.
REQ-026 flush_out SHALL be 1 exactly in the cycle after any redirect, else 0.
REQ-027 PC+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000); no overflow flag.
REQ-028 Latency: imem_ack at edge N -> instr_out/valid_out visible after edge N (one cycle), when unstalled.

Reset
REQ-029 reset_n=0 SHALL immediately force: state FETCH, PC=0, imem_addr=0, imem_req=1 after deassert (0 while asserted), instr_out=0, pc4_out=0, valid_out=0, flush_out=0, holding buffer and redirect register empty.
REQ-030 Reset mid-DRAIN or mid-HOLD SHALL abandon the operation; first fetch after release is address 0.

Verification
REQ-031 Reset release, ack every cycle, no stall -> imem_addr 0,4,8; instr_out follows imem_data one cycle later; pc4_out 4,8,12; valid_out=1 from 2nd edge.
REQ-032 stall=1 for 3 cycles while ack arrives at addr 8 -> IF/ID frozen, imem_req=0 in HOLD, addr-8 instruction appears one cycle after stall drops, next fetch addr 12.
REQ-033 leap=1, target=0x00000103, valid_out=1, ack same cycle -> next imem_addr 0x00000100, flush_out 1 for one cycle, valid_out 0, acked data never reaches instr_out.
REQ-034 leap with ack=0 at addr 0x20, ack delayed 4 cycles, target 0x40 -> addr holds 0x20 until ack, then 0x40; instr from 0x20 discarded; flush_out single pulse.
REQ-035 PC=0xFFFFFFFC fetched -> next imem_addr 0x00000000, pc4_out 0x00000000; leap with stall=1 -> no redirect, no flush; reset_n low in DRAIN -> PC 0 at once.

Source files
------------

// File: rtl/fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect
// Purpose  : Instruction-fetch stage with IF/ID register, one-entry stall
//            holding buffer and branch/jump redirect handling.
//            FETCH : normal fetching; captures acked data into IF/ID.
//            HOLD  : a fetch completed while stalled; data parked in the
//                    holding buffer, no new memory request.
//            DRAIN : a redirect arrived while a fetch was outstanding; the
//                    old request is kept until ack, then the PC jumps.
// Ports    : clk        - pipeline clock (rising edge)
//            reset_n    - async-assert, active-low reset
//            leap       - redirect request from decode
//            target     - redirect PC (bit 0 MSB, bits 30:31 ignored)
//            stall      - hazard stall, IF/ID must hold
//            imem_req   - instruction memory request
//            imem_addr  - fetch address (registered PC)
//            imem_ack   - memory completion, imem_data valid same cycle
//            imem_data  - fetched instruction
//            instr_out  - IF/ID instruction
//            pc4_out    - IF/ID PC+4 (link value)
//            valid_out  - IF/ID holds a live instruction
//            flush_out  - one-cycle pulse after a redirect
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        leap,
  input  logic [0:31] target,
  input  logic        stall,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_data,
  output logic [0:31] instr_out,
  output logic [0:31] pc4_out,
  output logic        valid_out,
  output logic        flush_out
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [0:31] pc_q, pc_d;
  logic [0:31] instr_q, instr_d;
  logic [0:31] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic [0:31] hbuf_instr_q, hbuf_instr_d;
  logic [0:31] hbuf_pc4_q, hbuf_pc4_d;
  logic [0:31] redir_q, redir_d;

  logic        w_redirect;
  logic [0:31] w_pc_plus4;
  logic [0:31] w_tgt;
  logic        unused_tgt_lsbs;

  // A redirect only counts when decode holds a live instruction and is not
  // stalled; otherwise the leap belongs to a bubble or a held instruction.
  assign w_redirect      = leap & valid_q & ~stall;
  assign w_pc_plus4      = pc_q + 32'd4;  // wraps modulo 2^32
  assign w_tgt           = {target[0:29], 2'b00};
  assign unused_tgt_lsbs = ^target[30:31];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
      hbuf_instr_q <= '0;
      hbuf_pc4_q   <= '0;
      redir_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
      hbuf_instr_q <= hbuf_instr_d;
      hbuf_pc4_q   <= hbuf_pc4_d;
      redir_q      <= redir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    flush_d      = w_redirect;
    hbuf_instr_d = hbuf_instr_q;
    hbuf_pc4_d   = hbuf_pc4_q;
    redir_d      = redir_q;

    case (state_q)
      FETCH: begin
        if (w_redirect) begin
          valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = w_tgt;
          end else begin
            // Memory still owns the old address; finish it before jumping.
            redir_d = w_tgt;
            state_d = DRAIN;
          end
        end else if (stall) begin
          if (imem_ack) begin
            hbuf_instr_d = imem_data;
            hbuf_pc4_d   = w_pc_plus4;
            pc_d         = w_pc_plus4;
            state_d      = HOLD;
          end
        end else if (imem_ack) begin
          instr_d = imem_data;
          pc4_d   = w_pc_plus4;
          valid_d = 1'b1;
          pc_d    = w_pc_plus4;
        end else begin
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (w_redirect) begin
          pc_d    = w_tgt;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = hbuf_instr_q;
          pc4_d   = hbuf_pc4_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        valid_d = 1'b0;
        if (imem_ack) begin
          pc_d    = redir_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Request drops while reset is asserted and while parked in HOLD.
  assign imem_req  = reset_n & (state_q != HOLD);
  assign imem_addr = pc_q;
  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;
  assign flush_out = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect
// Purpose  : Directed self-checking bench for fetch_redirect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect;

  logic        clk;
  logic        reset_n;
  logic        leap;
  logic [0:31] target;
  logic        stall;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_ack;
  logic [0:31] imem_data;
  logic [0:31] instr_out;
  logic [0:31] pc4_out;
  logic        valid_out;
  logic        flush_out;

  int n_chk = 0;
  int n_err = 0;

  fetch_redirect u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .leap      (leap),
    .target    (target),
    .stall     (stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .instr_out (instr_out),
    .pc4_out   (pc4_out),
    .valid_out (valid_out),
    .flush_out (flush_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the bench's memory returns for a given address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic exp_all(input string tag, input logic [31:0] addr, input logic req,
                         input logic [31:0] instr, input logic [31:0] pc4,
                         input logic valid, input logic flush);
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    check({tag, ".instr"}, instr_out, instr);
    check({tag, ".pc4"},   pc4_out, pc4);
    check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, valid});
    check({tag, ".flush"}, {31'd0, flush_out}, {31'd0, flush});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic ack, input logic [31:0] data, input logic lp,
                     input logic [31:0] tgt, input logic stl);
    imem_ack  = ack;
    imem_data = data;
    leap      = lp;
    target    = tgt;
    stall     = stl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; leap = 1'b0; target = '0; stall = 1'b0;
    imem_ack = 1'b0; imem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_all("rst", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #1;
    check("rst_rel.req", {31'd0, imem_req}, 32'd1);

    // Straight-line fetch
    cyc(1'b1, memw(32'h0), 1'b0, 32'h0, 1'b0);
    exp_all("f0", 32'h4, 1'b1, memw(32'h0), 32'h4, 1'b1, 1'b0);
    cyc(1'b1, memw(32'h4), 1'b0, 32'h0, 1'b0);
    exp_all("f4", 32'h8, 1'b1, memw(32'h4), 32'h8, 1'b1, 1'b0);

    // Stall for 3 cycles while the fetch at 8 completes
    cyc(1'b1, memw(32'h8), 1'b0, 32'h0, 1'b1);
    exp_all("h1", 32'hC, 1'b0, memw(32'h4), 32'h8, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    exp_all("h2", 32'hC, 1'b0, memw(32'h4), 32'h8, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    exp_all("h3", 32'hC, 1'b0, memw(32'h4), 32'h8, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp_all("hrel", 32'hC, 1'b1, memw(32'h8), 32'hC, 1'b1, 1'b0);

    // Redirect with ack in the same cycle; acked data discarded
    cyc(1'b1, memw(32'hC), 1'b1, 32'h0000_0103, 1'b0);
    exp_all("rd", 32'h100, 1'b1, memw(32'h8), 32'hC, 1'b0, 1'b1);
    cyc(1'b1, memw(32'h100), 1'b0, 32'h0, 1'b0);
    exp_all("rd_f", 32'h104, 1'b1, memw(32'h100), 32'h104, 1'b1, 1'b0);

    // Move to 0x1C, fetch it so 0x20 is requested with a live IF/ID
    cyc(1'b1, memw(32'h104), 1'b1, 32'h1C, 1'b0);
    exp_all("rd1c", 32'h1C, 1'b1, memw(32'h100), 32'h104, 1'b0, 1'b1);
    cyc(1'b1, memw(32'h1C), 1'b0, 32'h0, 1'b0);
    exp_all("f1c", 32'h20, 1'b1, memw(32'h1C), 32'h20, 1'b1, 1'b0);

    // Redirect with ack outstanding -> DRAIN; further leaps ignored
    cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    exp_all("dr0", 32'h20, 1'b1, memw(32'h1C), 32'h20, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 32'h80, 1'b0);
      exp_all("drw", 32'h20, 1'b1, memw(32'h1C), 32'h20, 1'b0, 1'b0);
    end
    cyc(1'b1, memw(32'h20), 1'b1, 32'h80, 1'b0);
    exp_all("drack", 32'h40, 1'b1, memw(32'h1C), 32'h20, 1'b0, 1'b0);
    // leap while valid_out=0 is ignored
    cyc(1'b1, memw(32'h40), 1'b1, 32'h80, 1'b0);
    exp_all("f40", 32'h44, 1'b1, memw(32'h40), 32'h44, 1'b1, 1'b0);

    // leap during stall is ignored
    cyc(1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    exp_all("lstall", 32'h44, 1'b1, memw(32'h40), 32'h44, 1'b1, 1'b0);

    // PC wrap at the top of the address space; target LSBs ignored
    cyc(1'b1, memw(32'h44), 1'b1, 32'hFFFF_FFFF, 1'b0);
    exp_all("rtop", 32'hFFFF_FFFC, 1'b1, memw(32'h40), 32'h44, 1'b0, 1'b1);
    cyc(1'b1, memw(32'hFFFF_FFFC), 1'b0, 32'h0, 1'b0);
    exp_all("wrap", 32'h0, 1'b1, memw(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b0);
    cyc(1'b1, memw(32'h0), 1'b0, 32'h0, 1'b0);
    exp_all("f0b", 32'h4, 1'b1, memw(32'h0), 32'h4, 1'b1, 1'b0);

    // Reset asserted mid-DRAIN takes effect immediately
    cyc(1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    exp_all("dr2", 32'h4, 1'b1, memw(32'h0), 32'h4, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    exp_all("rst_dr", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;
    cyc(1'b1, memw(32'h0), 1'b0, 32'h0, 1'b0);
    exp_all("post_dr", 32'h4, 1'b1, memw(32'h0), 32'h4, 1'b1, 1'b0);

    // Reset asserted mid-HOLD abandons the held instruction
    cyc(1'b1, memw(32'h4), 1'b0, 32'h0, 1'b1);
    exp_all("h_pre", 32'h8, 1'b0, memw(32'h0), 32'h4, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    exp_all("rst_h", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;
    cyc(1'b1, memw(32'h0), 1'b0, 32'h0, 1'b0);
    exp_all("post_h", 32'h4, 1'b1, memw(32'h0), 32'h4, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
